// File: rtl/lcd_cmd_arbiter.sv
// Packet-level round-robin arbiter sharing the 9-bit SPI command FIFO between two producers.
// Packets stay contiguous; a stall watchdog revokes the grant from an owner that stops mid-packet.
module lcd_cmd_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [8:0] req0_cmd,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [8:0] req1_cmd,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic [8:0] fifo_din,
    output logic       fifo_wr,
    input  logic       fifo_full,
    output logic [1:0] grant,
    output logic       timeout_evt
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state;
    logic          pref;
    logic [CW-1:0] stall_cnt;

    logic          own0;
    logic          own1;
    logic          owner_valid;
    logic          owner_last;
    logic [8:0]    owner_cmd;
    logic          xfer;

    // Write port is a pass-through from the current owner, gated off during reset.
    always_comb begin
        own0        = (state == OWN0);
        own1        = (state == OWN1);
        owner_valid = (own0 & req0_valid) | (own1 & req1_valid);
        owner_last  = own1 ? req1_last : req0_last;
        owner_cmd   = own1 ? req1_cmd : req0_cmd;
        xfer        = owner_valid & ~fifo_full & ~rst;
        req0_ready  = own0 & ~fifo_full & ~rst;
        req1_ready  = own1 & ~fifo_full & ~rst;
        fifo_wr     = xfer;
        fifo_din    = xfer ? owner_cmd : 9'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pref        <= 1'b0;
            stall_cnt   <= '0;
            grant       <= 2'b00;
            timeout_evt <= 1'b0;
        end else begin
            timeout_evt <= 1'b0;
            case (state)
                IDLE: begin
                    stall_cnt <= '0;
                    if (req0_valid && (!req1_valid || !pref)) begin
                        state <= OWN0;
                        grant <= 2'b01;
                    end else if (req1_valid) begin
                        state <= OWN1;
                        grant <= 2'b10;
                    end
                end
                OWN0, OWN1: begin
                    if (xfer) begin
                        stall_cnt <= '0;
                        if (owner_last) begin
                            state <= IDLE;
                            grant <= 2'b00;
                            pref  <= own0;
                        end
                    end else if (!owner_valid) begin
                        // Full-FIFO stalls with valid high neither count nor clear.
                        if (stall_cnt != CW'(TIMEOUT)) begin
                            stall_cnt <= stall_cnt + CW'(1);
                        end
                        if (stall_cnt == CW'(TIMEOUT - 1)) begin
                            state       <= IDLE;
                            grant       <= 2'b00;
                            pref        <= own0;
                            timeout_evt <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Self-checking bench for lcd_cmd_arbiter: a cycle model of owner/preference/stall rules checked
// every cycle, plus hand-computed expectations at key points of each directed scenario.
module tb_lcd_cmd_arbiter;

    localparam int TO = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid;
    logic [8:0] req0_cmd;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [8:0] req1_cmd;
    logic       req1_last;
    logic       req1_ready;
    logic [8:0] fifo_din;
    logic       fifo_wr;
    logic       fifo_full;
    logic [1:0] grant;
    logic       timeout_evt;

    int checks = 0;
    int errors = 0;
    int tevt_seen = 0;
    logic [8:0] wr_log[$];
    logic [8:0] exp_log[$] = '{9'h02A, 9'h100, 9'h1FF,
                               9'h0A1, 9'h0A2, 9'h1B1, 9'h1B2, 9'h0C1, 9'h1C1,
                               9'h1D1, 9'h1D2, 9'h1D3,
                               9'h0E1, 9'h1E1, 9'h0E2,
                               9'h1F1, 9'h0F1, 9'h1F2, 9'h1F3};

    lcd_cmd_arbiter #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_cmd   (req0_cmd),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_cmd   (req1_cmd),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .fifo_din   (fifo_din),
        .fifo_wr    (fifo_wr),
        .fifo_full  (fifo_full),
        .grant      (grant),
        .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    function automatic void checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endfunction

    // One cycle of inputs, driven just after the rising edge; returns at the falling edge.
    task automatic applyStimulus(input logic r,
                                 input logic v0, input logic [8:0] c0, input logic l0,
                                 input logic v1, input logic [8:0] c1, input logic l1,
                                 input logic full);
        @(posedge clk);
        #1;
        rst        = r;
        req0_valid = v0;
        req0_cmd   = c0;
        req0_last  = l0;
        req1_valid = v1;
        req1_cmd   = c1;
        req1_last  = l1;
        fifo_full  = full;
        @(negedge clk);
    endtask

    // Model: owner (-1 none), tie-winner, stall run length; compared every cycle.
    initial begin : model
        int own;
        int prf;
        int stall;
        bit tevt;
        bit ew;
        logic [8:0] ed;
        logic [1:0] v;
        logic [1:0] l;
        logic [8:0] c[2];
        own = -1;
        prf = 0;
        stall = 0;
        tevt = 1'b0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            v    = {req1_valid, req0_valid};
            l    = {req1_last, req0_last};
            c[0] = req0_cmd;
            c[1] = req1_cmd;
            ew   = !rst && (own >= 0) && v[own] && !fifo_full;
            ed   = ew ? c[own] : 9'h000;
            checkOutput("grant", int'(grant), (own < 0) ? 0 : (1 << own));
            checkOutput("fifo_wr", int'(fifo_wr), int'(ew));
            checkOutput("fifo_din", int'(fifo_din), int'(ed));
            checkOutput("req0_ready", int'(req0_ready), int'(!rst && own == 0 && !fifo_full));
            checkOutput("req1_ready", int'(req1_ready), int'(!rst && own == 1 && !fifo_full));
            checkOutput("timeout_evt", int'(timeout_evt), int'(tevt));
            if (fifo_wr) wr_log.push_back(fifo_din);
            if (timeout_evt) tevt_seen++;
            tevt = 1'b0;
            if (rst) begin
                own = -1;
                prf = 0;
                stall = 0;
            end else if (own < 0) begin
                stall = 0;
                if (v[0] && v[1]) own = prf;
                else if (v[0]) own = 0;
                else if (v[1]) own = 1;
            end else if (ew) begin
                stall = 0;
                if (l[own]) begin
                    prf = 1 - own;
                    own = -1;
                end
            end else if (!v[own]) begin
                stall++;
                if (stall >= TO) begin
                    prf = 1 - own;
                    own = -1;
                    tevt = 1'b1;
                end
            end
        end
    end

    initial begin : guard
        #200000;
        $display("[TB] FAIL sim_timeout: simulation did not complete");
        $fatal(1, "[TB] time limit");
    end

    initial begin : stimulus
        rst = 1'b1;
        req0_valid = 1'b0; req0_cmd = '0; req0_last = 1'b0;
        req1_valid = 1'b0; req1_cmd = '0; req1_last = 1'b0;
        fifo_full = 1'b0;

        // Reset state
        applyStimulus(1, 0, 9'h000, 0, 0, 9'h000, 0, 0);
        checkOutput("reset grant", int'(grant), 0);
        checkOutput("reset fifo_wr", int'(fifo_wr), 0);
        checkOutput("reset readies", int'({req1_ready, req0_ready}), 0);
        checkOutput("reset timeout_evt", int'(timeout_evt), 0);
        applyStimulus(1, 0, 9'h000, 0, 0, 9'h000, 0, 0);

        // Single requester, 3-word packet
        applyStimulus(0, 1, 9'h02A, 0, 0, 9'h000, 0, 0);
        checkOutput("t1 idle grant", int'(grant), 0);
        checkOutput("t1 idle wr", int'(fifo_wr), 0);
        applyStimulus(0, 1, 9'h02A, 0, 0, 9'h000, 0, 0);
        checkOutput("t1 w0 grant", int'(grant), 1);
        checkOutput("t1 w0 din", int'(fifo_din), 'h02A);
        applyStimulus(0, 1, 9'h100, 0, 0, 9'h000, 0, 0);
        checkOutput("t1 w1 din", int'(fifo_din), 'h100);
        applyStimulus(0, 1, 9'h1FF, 1, 0, 9'h000, 0, 0);
        checkOutput("t1 w2 din", int'(fifo_din), 'h1FF);
        checkOutput("t1 w2 wr", int'(fifo_wr), 1);
        applyStimulus(0, 0, 9'h000, 0, 0, 9'h000, 0, 0);
        checkOutput("t1 end grant", int'(grant), 0);

        // Contention after reset: req0 wins, packets stay contiguous, then alternate
        applyStimulus(1, 0, 9'h000, 0, 0, 9'h000, 0, 0);
        applyStimulus(0, 1, 9'h0A1, 0, 1, 9'h1B1, 0, 0);
        applyStimulus(0, 1, 9'h0A1, 0, 1, 9'h1B1, 0, 0);
        checkOutput("t2 first owner", int'(grant), 1);
        checkOutput("t2 req1 blocked", int'(req1_ready), 0);
        applyStimulus(0, 1, 9'h0A2, 1, 1, 9'h1B1, 0, 0);
        checkOutput("t2 a2 din", int'(fifo_din), 'h0A2);
        applyStimulus(0, 0, 9'h000, 0, 1, 9'h1B1, 0, 0);
        checkOutput("t2 gap grant", int'(grant), 0);
        applyStimulus(0, 0, 9'h000, 0, 1, 9'h1B1, 0, 0);
        checkOutput("t2 second owner", int'(grant), 2);
        checkOutput("t2 b1 din", int'(fifo_din), 'h1B1);
        applyStimulus(0, 0, 9'h000, 0, 1, 9'h1B2, 1, 0);
        applyStimulus(0, 1, 9'h0C1, 1, 1, 9'h1C1, 1, 0);
        applyStimulus(0, 1, 9'h0C1, 1, 1, 9'h1C1, 1, 0);
        checkOutput("t2 rr back to req0", int'(grant), 1);
        applyStimulus(0, 0, 9'h000, 0, 1, 9'h1C1, 1, 0);
        applyStimulus(0, 0, 9'h000, 0, 1, 9'h1C1, 1, 0);
        checkOutput("t2 rr req1", int'(grant), 2);
        applyStimulus(0, 0, 9'h000, 0, 0, 9'h000, 0, 0);

        // Backpressure in the middle of req1's packet (longer than the watchdog limit)
        applyStimulus(0, 0, 9'h000, 0, 1, 9'h1D1, 0, 0);
        applyStimulus(0, 0, 9'h000, 0, 1, 9'h1D1, 0, 0);
        checkOutput("t3 d1 din", int'(fifo_din), 'h1D1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 9'h000, 0, 1, 9'h1D2, 0, 1);
            checkOutput("t3 full ready", int'(req1_ready), 0);
            checkOutput("t3 full wr", int'(fifo_wr), 0);
            checkOutput("t3 full grant", int'(grant), 2);
            checkOutput("t3 full tevt", int'(timeout_evt), 0);
        end
        applyStimulus(0, 0, 9'h000, 0, 1, 9'h1D2, 0, 0);
        checkOutput("t3 d2 din", int'(fifo_din), 'h1D2);
        applyStimulus(0, 0, 9'h000, 0, 1, 9'h1D3, 1, 0);
        applyStimulus(0, 0, 9'h000, 0, 0, 9'h000, 0, 0);
        checkOutput("t3 tevt none", tevt_seen, 0);

        // Watchdog: req0 stalls mid-packet while req1 waits
        applyStimulus(0, 1, 9'h0E1, 0, 0, 9'h000, 0, 0);
        applyStimulus(0, 1, 9'h0E1, 0, 0, 9'h000, 0, 0);
        checkOutput("t4 e1 din", int'(fifo_din), 'h0E1);
        for (int i = 0; i < TO; i++) begin
            applyStimulus(0, 0, 9'h000, 0, 1, 9'h1E1, 1, 0);
            checkOutput("t4 stall grant", int'(grant), 1);
            checkOutput("t4 stall tevt", int'(timeout_evt), 0);
        end
        applyStimulus(0, 1, 9'h0E2, 1, 1, 9'h1E1, 1, 0);
        checkOutput("t4 revoked grant", int'(grant), 0);
        checkOutput("t4 tevt pulse", int'(timeout_evt), 1);
        applyStimulus(0, 1, 9'h0E2, 1, 1, 9'h1E1, 1, 0);
        checkOutput("t4 req1 first", int'(grant), 2);
        checkOutput("t4 tevt one cycle", int'(timeout_evt), 0);
        checkOutput("t4 e1b din", int'(fifo_din), 'h1E1);
        applyStimulus(0, 1, 9'h0E2, 1, 0, 9'h000, 0, 0);
        applyStimulus(0, 1, 9'h0E2, 1, 0, 9'h000, 0, 0);
        checkOutput("t4 req0 later", int'(grant), 1);
        applyStimulus(0, 0, 9'h000, 0, 0, 9'h000, 0, 0);

        // Reset while OWN1 is transferring
        applyStimulus(0, 0, 9'h000, 0, 1, 9'h1F1, 0, 0);
        applyStimulus(0, 0, 9'h000, 0, 1, 9'h1F1, 0, 0);
        checkOutput("t5 f1 din", int'(fifo_din), 'h1F1);
        applyStimulus(1, 0, 9'h000, 0, 1, 9'h1F2, 0, 0);
        checkOutput("t5 reset no write", int'(fifo_wr), 0);
        checkOutput("t5 reset ready", int'(req1_ready), 0);
        applyStimulus(0, 1, 9'h0F1, 1, 1, 9'h1F2, 0, 0);
        checkOutput("t5 after reset grant", int'(grant), 0);
        applyStimulus(0, 1, 9'h0F1, 1, 1, 9'h1F2, 0, 0);
        checkOutput("t5 pref cleared", int'(grant), 1);
        applyStimulus(0, 0, 9'h000, 0, 1, 9'h1F2, 0, 0);
        applyStimulus(0, 0, 9'h000, 0, 1, 9'h1F2, 0, 0);
        checkOutput("t5 req1 regrant", int'(grant), 2);
        applyStimulus(0, 0, 9'h000, 0, 1, 9'h1F3, 1, 0);
        checkOutput("t5 f3 din", int'(fifo_din), 'h1F3);
        applyStimulus(0, 0, 9'h000, 0, 0, 9'h000, 0, 0);
        checkOutput("t5 end grant", int'(grant), 0);

        @(posedge clk);
        #1;
        checkOutput("log length", wr_log.size(), exp_log.size());
        foreach (exp_log[i]) begin
            checkOutput($sformatf("log word %0d", i),
                        (i < wr_log.size()) ? int'(wr_log[i]) : -1, int'(exp_log[i]));
        end
        checkOutput("timeout pulses", tevt_seen, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
